fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage that sits directly upstream of the mini processor's decode/execute core. Holds the 8-bit program counter and a loadable instruction memory. Presents one instruction per cycle to the core over a valid/ready handshake, and accepts PC redirects (branch/jump) from the core with a flush of the in-flight slot. Stops on a HALT opcode until reset.

## Interface
- ADDR_W, 8: program counter / memory address width; memory depth is 2^ADDR_W words.
- INSTR_W, 16: instruction width.
- HALT_OP, 4'hF: opcode (instr[INSTR_W-1:INSTR_W-4]) that halts fetching.

- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk.
- prog_we  in  1  instruction-memory write enable.
- prog_addr  in  ADDR_W  write address.
- prog_data  in  INSTR_W  write data.
- start  in  1  begin fetching from PC 0; honoured only in IDLE.
- redirect_valid  in  1  core requests PC change; honoured only in RUN.
- redirect_pc  in  ADDR_W  new PC.
- out_ready  in  1  core can accept an instruction this cycle.
- out_valid  out  1  out_instr/out_pc hold a valid instruction.
- out_instr  out  INSTR_W  fetched instruction.
- out_pc  out  ADDR_W  address of out_instr.
- halted  out  1  fetch unit is in HALT.

## Operation
- States: IDLE, RUN, HALT.
  - Reset enters IDLE.
  - IDLE -> RUN on start.
  - RUN -> HALT when a HALT_OP instruction is loaded into the output register.
  - HALT is left only by reset.
- Memory: register array, combinational read at pc, written on the clock edge when prog_we=1.
  - Writes are accepted in every state.
  - A read of the address being written in the same cycle returns the old contents.
  - Memory contents are not cleared by reset.
- Load condition (RUN, no redirect, and out_valid=0 or out_ready=1):
  - out_instr <= mem[pc], out_pc <= pc, out_valid <= 1.
  - pc <= pc+1, modulo 2^ADDR_W (255 wraps to 0).
- Stall (RUN, out_valid=1, out_ready=0): out_instr, out_pc and pc all hold.
- Accept without reload (a handshake with no new load, e.g. in HALT): out_valid <= 0.
- Redirect (RUN, redirect_valid=1):
  - pc <= redirect_pc, out_valid <= 0. Any pending instruction is dropped, even if out_ready=1 that cycle.
  - Redirect has priority over a load and over a HALT transition in the same cycle.
- HALT load:
  - The HALT_OP instruction is itself presented (out_valid=1) and pc is not incremented.
  - State goes to HALT on the same edge.
  - In HALT, the instruction stays valid until accepted, then out_valid <= 0 permanently.
  - redirect_valid and start are ignored in HALT.
- IDLE: out_valid=0, pc=0. redirect_valid is ignored.
- Reset (any state, including mid-stall): state=IDLE, pc=0, out_valid=0, out_instr=0, out_pc=0, halted=0.

## Timing
- start sampled at edge k: state=RUN after k. First load at edge k+1, so out_valid=1 with out_pc=0 after k+1.
- Throughput: 1 instruction/cycle while out_ready=1 and no redirect.
- Redirect sampled at edge k: out_valid=0 after k. The instruction at redirect_pc is valid after k+1 (one bubble).
- halted rises on the edge that loads the HALT_OP instruction.
- out_valid and out_instr are registered outputs; no combinational path from out_ready or redirect_valid to any output.

## Test plan
- Reset/start:
  - Load mem[0..3] = 16'h1001, 16'h1002, 16'h1003, 16'h1004.
  - Pulse start with out_ready=1.
  - Required: out_valid first high one cycle after RUN, out_pc 0,1,2,3 on consecutive cycles with matching out_instr.
- Stall:
  - Hold out_ready=0 for 3 cycles while out_pc=1.
  - Required: out_instr stays 16'h1002 and out_pc stays 1. After release, out_pc=2 on the next cycle with no skip or duplicate.
- Redirect/flush:
  - Assert redirect_valid with redirect_pc=8'h40 while out_pc=2 is pending.
  - Required: out_valid=0 for one cycle, then out_pc=8'h40 with out_instr=mem[64]; instruction 2 is never accepted.
- Wrap:
  - Redirect to 8'hFE with mem[FE]=16'h2222, mem[FF]=16'h3333, mem[0]=16'h1001.
  - Required: out_pc sequence FE, FF, 00.
- HALT:
  - Put mem[4]=16'hF000 and run from 0.
  - Required: F000 presented with out_pc=4 and halted=1 on that edge. After acceptance out_valid=0 forever. A redirect_valid issued in HALT has no effect. rst_n=0 for one cycle returns to IDLE with all outputs 0.
- Reset mid-stall:
  - Assert rst_n=0 while out_valid=1 and out_ready=0.
  - Required: the next cycle shows out_valid=0 and pc=0, and memory contents are preserved (a restart fetches 16'h1001 at pc 0).

Source files
------------

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch-to-core instruction handshake and redirect bus
//
// Ports (signals):
//   out_valid      fetch -> core  out_instr/out_pc hold a valid instruction
//   out_instr      fetch -> core  fetched instruction
//   out_pc         fetch -> core  address of out_instr
//   out_ready      core -> fetch  core accepts the instruction this cycle
//   redirect_valid core -> fetch  branch/jump request
//   redirect_pc    core -> fetch  new program counter
// Modports: master (fetch unit side), slave (core side).
interface fetch_unit_if #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16
);
    logic               out_valid;
    logic [INSTR_W-1:0] out_instr;
    logic [ADDR_W-1:0]  out_pc;
    logic               out_ready;
    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_pc;

    modport master (
        output out_valid,
        output out_instr,
        output out_pc,
        input  out_ready,
        input  redirect_valid,
        input  redirect_pc
    );

    modport slave (
        input  out_valid,
        input  out_instr,
        input  out_pc,
        output out_ready,
        output redirect_valid,
        output redirect_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with PC, program memory, redirect and halt
//
// Ports:
//   clk        in   clock, all state updates on rising edge
//   rst_n      in   synchronous active-low reset
//   prog_we    in   program-memory write enable
//   prog_addr  in   program-memory write address
//   prog_data  in   program-memory write data
//   start      in   begin fetching from PC 0 (IDLE only)
//   halted     out  fetch unit has stopped on a HALT opcode
//   bus        fetch_unit_if.master: out_valid/out_instr/out_pc/out_ready,
//              redirect_valid/redirect_pc
module fetch_unit #(
    parameter int         ADDR_W  = 8,
    parameter int         INSTR_W = 16,
    parameter logic [3:0] HALT_OP = 4'hF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               prog_we,
    input  logic [ADDR_W-1:0]  prog_addr,
    input  logic [INSTR_W-1:0] prog_data,
    input  logic               start,
    output logic               halted,
    fetch_unit_if.master       bus
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [INSTR_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] fetch_instr;
    logic               fetch_is_halt;

    logic               do_redirect;
    logic               do_load;

    logic               out_valid_q;
    logic [INSTR_W-1:0] out_instr_q;
    logic [ADDR_W-1:0]  out_pc_q;

    // Program memory: no reset so the program survives a core reset.
    // Reads are combinational, so a same-cycle write is seen only next cycle.
    always_ff @(posedge clk) begin
        if (prog_we) begin
            mem[prog_addr] <= prog_data;
        end
    end

    assign fetch_instr   = mem[pc];
    assign fetch_is_halt = (fetch_instr[INSTR_W-1 -: 4] == HALT_OP);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = RUN;
            RUN:  if (do_load && fetch_is_halt) state_next = HALT;
            HALT: state_next = HALT;
            default: state_next = IDLE;
        endcase
    end

    // Output / control decode. Redirect outranks both a load and a halt.
    always_comb begin
        do_redirect = 1'b0;
        do_load     = 1'b0;
        halted      = 1'b0;
        case (state)
            RUN: begin
                do_redirect = bus.redirect_valid;
                do_load     = !bus.redirect_valid && (!out_valid_q || bus.out_ready);
            end
            HALT: halted = 1'b1;
            default: ;
        endcase
    end

    // Program counter and output register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc          <= '0;
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_pc_q    <= '0;
        end else if (do_redirect) begin
            pc          <= bus.redirect_pc;
            out_valid_q <= 1'b0;
        end else if (do_load) begin
            out_valid_q <= 1'b1;
            out_instr_q <= fetch_instr;
            out_pc_q    <= pc;
            // The halt instruction keeps pc pointing at itself.
            if (!fetch_is_halt) begin
                pc <= pc + ADDR_W'(1);
            end
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_instr = out_instr_q;
    assign bus.out_pc    = out_pc_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;
    logic        clk;
    logic        rst_n;
    logic        prog_we;
    logic [7:0]  prog_addr;
    logic [15:0] prog_data;
    logic        start;
    logic        halted;

    int vectors;
    int miscompares;

    fetch_unit_if #(.ADDR_W(8), .INSTR_W(16)) bus ();

    fetch_unit #(.ADDR_W(8), .INSTR_W(16), .HALT_OP(4'hF)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .start     (start),
        .halted    (halted),
        .bus       (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic prog_write(input logic [7:0] addr, input logic [15:0] data);
        prog_we   = 1'b1;
        prog_addr = addr;
        prog_data = data;
        tick();
        prog_we   = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        start = 1'b0;
        bus.out_ready = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 8'h00;
        prog_we = 1'b0;
        prog_addr = 8'h00;
        prog_data = 16'h0000;
        rst_n = 1'b0;
        tick();
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %0h want 0", bus.out_valid); end
        vectors++; if (bus.out_pc !== 8'h00) begin miscompares++; $display("FAIL reset_pc got %0h want 0", bus.out_pc); end
        vectors++; if (bus.out_instr !== 16'h0000) begin miscompares++; $display("FAIL reset_instr got %0h want 0", bus.out_instr); end
        vectors++; if (halted !== 1'b0) begin miscompares++; $display("FAIL reset_halted got %0h want 0", halted); end
        // Writes are accepted while reset is held.
        prog_write(8'h00, 16'h1001);
        rst_n = 1'b1;
        prog_write(8'h01, 16'h1002);
        prog_write(8'h02, 16'h1003);
        prog_write(8'h03, 16'h1004);
        prog_write(8'h04, 16'h1005);
        prog_write(8'h40, 16'h4040);
        prog_write(8'h41, 16'h4141);
        prog_write(8'hFE, 16'h2222);
        prog_write(8'hFF, 16'h3333);
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL idle_valid got %0h want 0", bus.out_valid); end
    endtask

    task automatic test_start();
        logic [15:0] exp_instr [4];
        exp_instr[0] = 16'h1001; exp_instr[1] = 16'h1002;
        exp_instr[2] = 16'h1003; exp_instr[3] = 16'h1004;
        bus.out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL start_bubble got %0h want 0", bus.out_valid); end
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL start_valid%0d got %0h want 1", i, bus.out_valid); end
            vectors++; if (bus.out_pc !== 8'(i)) begin miscompares++; $display("FAIL start_pc%0d got %0h want %0h", i, bus.out_pc, i); end
            vectors++; if (bus.out_instr !== exp_instr[i]) begin miscompares++; $display("FAIL start_instr%0d got %0h want %0h", i, bus.out_instr, exp_instr[i]); end
        end
    endtask

    task automatic test_stall();
        do_reset();
        bus.out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        vectors++; if (bus.out_pc !== 8'h01) begin miscompares++; $display("FAIL stall_pre_pc got %0h want 1", bus.out_pc); end
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++; if (bus.out_pc !== 8'h01 || bus.out_instr !== 16'h1002 || bus.out_valid !== 1'b1)
                begin miscompares++; $display("FAIL stall_hold%0d got pc %0h instr %0h v %0h want pc 1 instr 1002 v 1", i, bus.out_pc, bus.out_instr, bus.out_valid); end
        end
        bus.out_ready = 1'b1;
        tick();
        vectors++; if (bus.out_pc !== 8'h02 || bus.out_instr !== 16'h1003)
            begin miscompares++; $display("FAIL stall_release got pc %0h instr %0h want pc 2 instr 1003", bus.out_pc, bus.out_instr); end
    endtask

    task automatic test_redirect();
        // out_pc=2 is pending and out_ready=1 on the redirect edge: it must be dropped.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 8'h40;
        tick();
        bus.redirect_valid = 1'b0;
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL redirect_bubble got %0h want 0", bus.out_valid); end
        tick();
        vectors++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 8'h40 || bus.out_instr !== 16'h4040)
            begin miscompares++; $display("FAIL redirect_target got v %0h pc %0h instr %0h want v 1 pc 40 instr 4040", bus.out_valid, bus.out_pc, bus.out_instr); end
        tick();
        vectors++; if (bus.out_pc !== 8'h41 || bus.out_instr !== 16'h4141)
            begin miscompares++; $display("FAIL redirect_next got pc %0h instr %0h want pc 41 instr 4141", bus.out_pc, bus.out_instr); end
    endtask

    task automatic test_wrap();
        logic [7:0]  exp_pc [3];
        logic [15:0] exp_instr [3];
        exp_pc[0] = 8'hFE; exp_pc[1] = 8'hFF; exp_pc[2] = 8'h00;
        exp_instr[0] = 16'h2222; exp_instr[1] = 16'h3333; exp_instr[2] = 16'h1001;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 8'hFE;
        tick();
        bus.redirect_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++; if (bus.out_valid !== 1'b1 || bus.out_pc !== exp_pc[i] || bus.out_instr !== exp_instr[i])
                begin miscompares++; $display("FAIL wrap%0d got v %0h pc %0h instr %0h want v 1 pc %0h instr %0h", i, bus.out_valid, bus.out_pc, bus.out_instr, exp_pc[i], exp_instr[i]); end
        end
    endtask

    task automatic test_halt();
        do_reset();
        prog_write(8'h04, 16'hF000);
        bus.out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        vectors++; if (bus.out_pc !== 8'h03 || halted !== 1'b0)
            begin miscompares++; $display("FAIL halt_pre got pc %0h halted %0h want pc 3 halted 0", bus.out_pc, halted); end
        tick();
        vectors++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 8'h04 || bus.out_instr !== 16'hF000 || halted !== 1'b1)
            begin miscompares++; $display("FAIL halt_load got v %0h pc %0h instr %0h halted %0h want v 1 pc 4 instr f000 halted 1", bus.out_valid, bus.out_pc, bus.out_instr, halted); end
        // Not accepted yet, and a redirect must be ignored.
        bus.out_ready = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 8'h40;
        tick();
        vectors++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 8'h04 || bus.out_instr !== 16'hF000)
            begin miscompares++; $display("FAIL halt_hold got v %0h pc %0h instr %0h want v 1 pc 4 instr f000", bus.out_valid, bus.out_pc, bus.out_instr); end
        bus.redirect_valid = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL halt_accept got %0h want 0", bus.out_valid); end
        bus.redirect_valid = 1'b1;
        start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++; if (bus.out_valid !== 1'b0 || halted !== 1'b1 || bus.out_pc !== 8'h04)
                begin miscompares++; $display("FAIL halt_stay%0d got v %0h halted %0h pc %0h want v 0 halted 1 pc 4", i, bus.out_valid, halted, bus.out_pc); end
        end
        bus.redirect_valid = 1'b0;
        start = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        vectors++; if (bus.out_valid !== 1'b0 || bus.out_pc !== 8'h00 || bus.out_instr !== 16'h0000 || halted !== 1'b0)
            begin miscompares++; $display("FAIL halt_reset got v %0h pc %0h instr %0h halted %0h want all 0", bus.out_valid, bus.out_pc, bus.out_instr, halted); end
        tick();
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL halt_idle got %0h want 0", bus.out_valid); end
    endtask

    task automatic test_reset_mid_stall();
        prog_write(8'h04, 16'h1005);
        bus.out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        bus.out_ready = 1'b0;
        tick();
        vectors++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 8'h01)
            begin miscompares++; $display("FAIL mid_stall_pre got v %0h pc %0h want v 1 pc 1", bus.out_valid, bus.out_pc); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        vectors++; if (bus.out_valid !== 1'b0 || bus.out_pc !== 8'h00 || bus.out_instr !== 16'h0000)
            begin miscompares++; $display("FAIL mid_stall_reset got v %0h pc %0h instr %0h want all 0", bus.out_valid, bus.out_pc, bus.out_instr); end
        // out_ready still low: the first load needs only out_valid=0.
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        vectors++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 8'h00 || bus.out_instr !== 16'h1001)
            begin miscompares++; $display("FAIL mid_stall_restart got v %0h pc %0h instr %0h want v 1 pc 0 instr 1001", bus.out_valid, bus.out_pc, bus.out_instr); end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_start();
        test_stall();
        test_redirect();
        test_wrap();
        test_halt();
        test_reset_mid_stall();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
